// File: rtl/oc_port_pkg.sv
// Shared encodings for the open/close port bank: per-channel debounce states
// and the edge-qualification modes.
package oc_port_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    CHK_HIGH  = 2'b01,
    IDLE_HIGH = 2'b10,
    CHK_LOW   = 2'b11
  } oc_state_e;

  localparam logic [1:0] MODE_BOTH   = 2'b00;
  localparam logic [1:0] MODE_RISE   = 2'b01;
  localparam logic [1:0] MODE_FALL   = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  function automatic logic rise_qualified(input logic [1:0] mode);
    return (mode == MODE_BOTH) || (mode == MODE_RISE) || (mode == MODE_TOGGLE);
  endfunction

  function automatic logic fall_qualified(input logic [1:0] mode);
    return (mode == MODE_BOTH) || (mode == MODE_FALL);
  endfunction

endpackage

// File: rtl/oc_port_chan.sv
// One switch channel: synchroniser, debounce FSM and debounced level.
// rise/fall are high during the cycle whose edge completes the debounce.
module oc_port_chan
  import oc_port_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic sw,
  output logic rise,
  output logic fall,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  oc_state_e              state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;

  always_ff @(posedge Clock) begin
    if (!Reset) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], sw};
  end

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rise     = 1'b0;
    fall     = 1'b0;
    unique case (state)
      IDLE_LOW: begin
        if (s) begin
          state_nx = CHK_HIGH;
          cnt_nx   = CW'(1);
        end
      end
      CHK_HIGH: begin
        if (!s) begin
          state_nx = IDLE_LOW;
          cnt_nx   = '0;
        end else if (cnt == CNT_DONE) begin
          state_nx = IDLE_HIGH;
          cnt_nx   = '0;
          rise     = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_nx = CHK_LOW;
          cnt_nx   = CW'(1);
        end
      end
      CHK_LOW: begin
        if (s) begin
          state_nx = IDLE_HIGH;
          cnt_nx   = '0;
        end else if (cnt == CNT_DONE) begin
          state_nx = IDLE_LOW;
          cnt_nx   = '0;
          fall     = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE_LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Level is the accepted one, so a pending change (CHK_*) still reports the old level.
  always_comb stable = (state == IDLE_HIGH) || (state == CHK_LOW);

endmodule

// File: rtl/oc_port_bank.sv
// Multi-channel open/close port controller: per-channel debounce, mode/enable
// edge qualification, toggled gate levels and a saturating event counter.
module oc_port_bank
  import oc_port_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] SwitchFlip,
  input  logic [1:0]          Mode,
  input  logic                Enable,
  output logic [CHANNELS-1:0] OpenClose,
  output logic [CHANNELS-1:0] GateOpen,
  output logic [CHANNELS-1:0] Stable,
  output logic [CNT_W-1:0]    EventCount
);

  logic [CHANNELS-1:0] rise, fall, oc_nx;
  logic [4:0]          pop;
  logic [CNT_W+4:0]    sum_nx;
  logic [CNT_W-1:0]    cnt_nx;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    oc_port_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_chan (
      .Clock (Clock),
      .Reset (Reset),
      .sw    (SwitchFlip[g]),
      .rise  (rise[g]),
      .fall  (fall[g]),
      .stable(Stable[g])
    );
  end

  always_comb begin
    oc_nx = '0;
    if (Enable) begin
      oc_nx = (rise_qualified(Mode) ? rise : '0) | (fall_qualified(Mode) ? fall : '0);
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) pop = pop + 5'(oc_nx[i]);
    sum_nx = {5'b0, EventCount} + {{CNT_W{1'b0}}, pop};
    cnt_nx = (|sum_nx[CNT_W+4:CNT_W]) ? '1 : sum_nx[CNT_W-1:0];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      OpenClose  <= '0;
      GateOpen   <= '0;
      EventCount <= '0;
    end else begin
      OpenClose  <= oc_nx;
      GateOpen   <= GateOpen ^ oc_nx;
      EventCount <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_oc_port_bank.sv
// Randomised and directed checks of oc_port_bank against a run-length reference model.
module tb_oc_port_bank;

  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int CW  = 8;
  localparam int MAX = (1 << CW) - 1;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [CH-1:0] SwitchFlip;
  logic [1:0]    Mode;
  logic          Enable;
  logic [CH-1:0] OpenClose, GateOpen, Stable;
  logic [CW-1:0] EventCount;

  int total = 0;
  int bad   = 0;

  oc_port_bank #(
    .CHANNELS   (CH),
    .SYNC_STAGES(SS),
    .DEBOUNCE   (DB),
    .CNT_W      (CW)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .SwitchFlip(SwitchFlip),
    .Mode      (Mode),
    .Enable    (Enable),
    .OpenClose (OpenClose),
    .GateOpen  (GateOpen),
    .Stable    (Stable),
    .EventCount(EventCount)
  );

  always #5 Clock = ~Clock;

  // Reference model: raw input reaches the filter SS edges later; a level is
  // accepted after DB consecutive samples differing from the current level.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_level, m_oc, m_gate;
  int            m_run[CH];
  int            m_cnt;

  always @(posedge Clock) begin : model
    logic [CH-1:0] s, lvl, rs, fl, oc;
    int            nrun;
    if (!Reset) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back('0);
      for (int i = 0; i < CH; i++) m_run[i] <= 0;
      m_level <= '0;
      m_oc    <= '0;
      m_gate  <= '0;
      m_cnt   <= 0;
    end else begin
      s = hist.pop_front();
      hist.push_back(SwitchFlip);
      lvl = m_level;
      rs  = '0;
      fl  = '0;
      for (int i = 0; i < CH; i++) begin
        nrun = 0;
        if (s[i] != lvl[i]) begin
          nrun = m_run[i] + 1;
          if (nrun == DB) begin
            lvl[i] = s[i];
            nrun   = 0;
            if (s[i]) rs[i] = 1'b1;
            else      fl[i] = 1'b1;
          end
        end
        m_run[i] <= nrun;
      end
      oc = '0;
      if (Enable) begin
        if (Mode != 2'b10) oc = oc | rs;
        if (Mode == 2'b00 || Mode == 2'b10) oc = oc | fl;
      end
      m_level <= lvl;
      m_oc    <= oc;
      m_gate  <= m_gate ^ oc;
      m_cnt   <= (m_cnt + $countones(oc) > MAX) ? MAX : m_cnt + $countones(oc);
    end
  end

  task automatic do_reset();
    Reset      = 1'b0;
    SwitchFlip = '0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset      = 1'b0;
    SwitchFlip = '1;
    Mode       = 2'b00;
    Enable     = 1'b1;
    repeat (3) @(negedge Clock);
    total++;
    if ({OpenClose, GateOpen, Stable, EventCount} !== '0) begin
      bad++;
      $display("FAIL reset_zero: got oc=%h gate=%h stable=%h cnt=%0d want all 0",
               OpenClose, GateOpen, Stable, EventCount);
    end
    Reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      total++;
      if ({OpenClose, GateOpen, Stable, EventCount} !== {m_oc, m_gate, m_level, CW'(m_cnt)}) begin
        bad++;
        $display("FAIL reset_model c=%0d: got %h/%h/%h/%0d want %h/%h/%h/%0d", c,
                 OpenClose, GateOpen, Stable, EventCount, m_oc, m_gate, m_level, m_cnt);
      end
      if (c == 4 || c == 5 || c == 6) begin
        total++;
        if (OpenClose !== ((c == 5) ? 4'hF : 4'h0)) begin
          bad++;
          $display("FAIL reset_latency c=%0d: got oc=%h want %h", c, OpenClose,
                   (c == 5) ? 4'hF : 4'h0);
        end
      end
      if (c == 6) begin
        total++;
        if ({GateOpen, Stable, EventCount} !== {4'hF, 4'hF, 8'd4}) begin
          bad++;
          $display("FAIL reset_after: got gate=%h stable=%h cnt=%0d want F/F/4",
                   GateOpen, Stable, EventCount);
        end
      end
    end
  endtask

  task automatic test_both_edges();
    int n = 0;
    int first = -1;
    int last = -1;
    do_reset();
    Mode = 2'b00;
    for (int c = 0; c < 24; c++) begin
      SwitchFlip = (c < 10) ? 4'h1 : 4'h0;
      @(negedge Clock);
      total++;
      if ({OpenClose, GateOpen, Stable, EventCount} !== {m_oc, m_gate, m_level, CW'(m_cnt)}) begin
        bad++;
        $display("FAIL both_model c=%0d: got %h/%h/%h/%0d want %h/%h/%h/%0d", c,
                 OpenClose, GateOpen, Stable, EventCount, m_oc, m_gate, m_level, m_cnt);
      end
      if (OpenClose[0]) begin
        n++;
        if (first < 0) first = c;
        last = c;
      end
    end
    total++;
    if (n != 2 || first != 5 || last - first != 10 || GateOpen[0] !== 1'b0 || EventCount !== 8'd2) begin
      bad++;
      $display("FAIL both_edges: got n=%0d first=%0d gap=%0d gate0=%b cnt=%0d want 2/5/10/0/2",
               n, first, last - first, GateOpen[0], EventCount);
    end
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      SwitchFlip = (c < 3) ? 4'h2 : 4'h0;
      @(negedge Clock);
      if (Stable[1] || OpenClose[1]) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || EventCount !== 8'd0) begin
      bad++;
      $display("FAIL glitch: got seen=%b cnt=%0d want 0/0", seen, EventCount);
    end
  endtask

  task automatic test_modes();
    int n;
    logic hi_at;
    logic [2:0] gates;
    for (int m = 1; m <= 2; m++) begin
      do_reset();
      Mode  = 2'(m);
      n     = 0;
      hi_at = 1'bx;
      for (int c = 0; c < 24; c++) begin
        SwitchFlip = (c < 10) ? 4'h1 : 4'h0;
        @(negedge Clock);
        if (OpenClose[0]) begin
          n++;
          hi_at = SwitchFlip[0];
        end
      end
      total++;
      if (n != 1 || hi_at !== ((m == 1) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL mode_%0d: got strobes=%0d during_high=%b want 1/%b", m, n, hi_at, m == 1);
      end
    end
    do_reset();
    Mode = 2'b11;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 16; c++) begin
        SwitchFlip = (c < 8) ? 4'h1 : 4'h0;
        @(negedge Clock);
      end
      gates[p] = GateOpen[0];
    end
    total++;
    if (gates !== 3'b101 || EventCount !== 8'd3) begin
      bad++;
      $display("FAIL mode_toggle: got gates(p2..p0)=%b cnt=%0d want 101/3", gates, EventCount);
    end
  endtask

  task automatic test_enable();
    logic st_seen = 1'b0;
    int n = 0;
    do_reset();
    Mode   = 2'b00;
    Enable = 1'b0;
    for (int c = 0; c < 24; c++) begin
      SwitchFlip = (c < 10) ? 4'h4 : 4'h0;
      @(negedge Clock);
      if (Stable[2]) st_seen = 1'b1;
      if (OpenClose != '0) n++;
    end
    total++;
    if (st_seen !== 1'b1 || n != 0 || GateOpen !== 4'h0 || EventCount !== 8'd0) begin
      bad++;
      $display("FAIL enable_off: got stable_seen=%b strobes=%0d gate=%h cnt=%0d want 1/0/0/0",
               st_seen, n, GateOpen, EventCount);
    end
    Enable = 1'b1;
    n      = 0;
    for (int c = 0; c < 24; c++) begin
      SwitchFlip = (c < 10) ? 4'h4 : 4'h0;
      @(negedge Clock);
      if (OpenClose[2]) n++;
    end
    total++;
    if (n != 2 || EventCount !== 8'd2) begin
      bad++;
      $display("FAIL enable_on: got strobes=%0d cnt=%0d want 2/2", n, EventCount);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    Mode   = 2'b00;
    Enable = 1'b1;
    for (int p = 0; p < 150; p++) begin
      for (int c = 0; c < 10; c++) begin
        SwitchFlip = (c < 5) ? 4'h8 : 4'h0;
        @(negedge Clock);
        total++;
        if (EventCount !== CW'(m_cnt)) begin
          bad++;
          $display("FAIL sat_model p=%0d c=%0d: got cnt=%0d want %0d", p, c, EventCount, m_cnt);
        end
      end
    end
    repeat (10) @(negedge Clock);
    total++;
    if (EventCount !== 8'd255) begin
      bad++;
      $display("FAIL saturation: got cnt=%0d want 255", EventCount);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int at = -1;
    do_reset();
    Mode       = 2'b00;
    SwitchFlip = 4'h1;
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      if (OpenClose[0]) begin
        n++;
        at = c;
      end
    end
    total++;
    if (n != 1 || at != 5 || EventCount !== 8'd1) begin
      bad++;
      $display("FAIL reset_mid: got strobes=%0d at=%0d cnt=%0d want 1/5/1", n, at, EventCount);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 5) == 0) SwitchFlip[i] = ~SwitchFlip[i];
      if ($urandom_range(0, 40) == 0) Mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 60) == 0) Enable = ~Enable;
      @(negedge Clock);
      total++;
      if ({OpenClose, GateOpen, Stable, EventCount} !== {m_oc, m_gate, m_level, CW'(m_cnt)}) begin
        bad++;
        $display("FAIL random_model c=%0d: got %h/%h/%h/%0d want %h/%h/%h/%0d", c,
                 OpenClose, GateOpen, Stable, EventCount, m_oc, m_gate, m_level, m_cnt);
      end
    end
  endtask

  initial begin
    Reset      = 1'b0;
    SwitchFlip = '0;
    Mode       = 2'b00;
    Enable     = 1'b1;
    test_reset();
    test_both_edges();
    test_glitch();
    test_modes();
    test_enable();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oc_port_bank.md
Name: oc_port_bank

Overview:
Multi-channel successor to the single-switch open/close port controller. Each channel synchronises and debounces one raw switch, detects qualified rise and fall events, and emits a one-cycle OpenClose strobe according to a selectable edge mode. Each channel also keeps a toggled gate level. A saturating event counter aggregates activity across all channels. The block sits between the raw board switches and the gate/lock control logic.

Parameters:
CHANNELS, 4, number of independent switch channels (1..16)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE, 4, consecutive stable synchronised samples required to accept a level change (>=2)
CNT_W, 8, width of EventCount

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-low
SwitchFlip  in  CHANNELS  raw asynchronous switch inputs
Mode  in  2  00 both edges, 01 rise only, 10 fall only, 11 toggle (rise only, gate toggles)
Enable  in  1  1 = strobes/counting allowed; 0 = events suppressed, filtering continues
OpenClose  out  CHANNELS  one-cycle strobe per qualified event
GateOpen  out  CHANNELS  per-channel level, toggles on each qualified event
Stable  out  CHANNELS  debounced switch level
EventCount  out  CNT_W  saturating total of qualified events

Behaviour:
- Reset: reset is Reset, synchronous, active-low; clock is Clock. While Reset=0 at a rising edge, the following clear: synchronisers to 0, all FSMs to IDLE_LOW with debounce counter 0, OpenClose=0, GateOpen=0, Stable=0, EventCount=0. Any in-flight debounce is discarded.
- Per-channel FSM, advancing on the synchronised input s:
  - IDLE_LOW: if s=1, go to CHK_HIGH with cnt=1; otherwise stay.
  - CHK_HIGH: if s=0, return to IDLE_LOW with cnt=0. If s=1 and cnt==DEBOUNCE-1, go to IDLE_HIGH and raise the rise event. Otherwise cnt++.
  - IDLE_HIGH: if s=0, go to CHK_LOW with cnt=1.
  - CHK_LOW: mirror of CHK_HIGH; completion goes to IDLE_LOW and raises the fall event.
- Stable is 1 in IDLE_HIGH and CHK_LOW, 0 otherwise. Stable is registered.
- Latency: for an input change held stable, the registered strobe rises on the (SYNC_STAGES+DEBOUNCE)th Clock edge after the change is first sampled. With defaults this is the 6th edge. The strobe lasts exactly one cycle.
- Glitches: a glitch shorter than DEBOUNCE synchronised cycles produces no event and no Stable change.
- Qualification per mode:
  - 00: rise or fall.
  - 01: rise only.
  - 10: fall only.
  - 11: rise only.
  - Qualified events are ANDed with Enable.
- Outputs per qualified event: OpenClose[i]=1 for one cycle and GateOpen[i] inverts on the same edge. With Mode 00 GateOpen therefore toggles twice per press.
- Mode and Enable are sampled on the edge the event completes. Changing either mid-debounce does not disturb the FSM.
- EventCount: on each edge, add the popcount of OpenClose-next. Saturate at 2^CNT_W-1 and never wrap. Multiple simultaneous channel events are all counted in the same cycle.
- Enable=0: FSMs and Stable keep updating, but OpenClose, GateOpen and EventCount hold. Events completed while disabled are lost and not queued.
- Switch held high through reset: after release it is treated as a fresh rise and produces a strobe after the normal latency.

Decomposition:
- Package oc_port_pkg:
  - FSM state encoding IDLE_LOW=2'b00, CHK_HIGH=2'b01, IDLE_HIGH=2'b10, CHK_LOW=2'b11.
  - Mode constants MODE_BOTH, MODE_RISE, MODE_FALL, MODE_TOGGLE.
- Sub-module oc_port_chan: one channel containing the synchroniser, debounce counter, FSM and Stable. Outputs are single-cycle rise/fall pulses.
- Top level: generate loop of CHANNELS instances, mode/enable qualification, GateOpen toggle registers, popcount and saturating adder.

Test Plan:
- Reset=0 for 3 cycles with SwitchFlip=4'hF -> all outputs 0. Release Reset -> OpenClose=4'hF on the 6th edge for 1 cycle, GateOpen=4'hF, EventCount=4, Stable=4'hF.
- Mode=00, channel 0 pulsed high for 10 cycles then low -> two OpenClose[0] strobes, 10 cycles apart. GateOpen[0] goes 1 then 0; EventCount=2.
- Channel 1 glitch high for 3 synchronised cycles (DEBOUNCE=4) -> no strobe, Stable[1] stays 0, EventCount unchanged.
- Mode=01 then Mode=10, one full press each -> rise-only strobe in the first case, fall-only strobe in the second. Mode=11 with 3 presses -> GateOpen toggles 1,0,1.
- Enable=0 during a press -> Stable follows the switch, with no OpenClose, no GateOpen change and no count. Enable=1 on the next press -> normal strobe.
- CNT_W=8, 300 single-channel events -> EventCount sticks at 255. Reset mid-debounce (after 2 stable cycles) -> no strobe, and the FSM restarts from IDLE_LOW.
